// File: rtl/wb_gpio8_pkg.sv
// Shared definitions for the wb_gpio8 Wishbone GPIO peripheral:
// register word offsets (wb_adr_i[3:2]) and the bus handshake states.
package wb_gpio8_pkg;

    localparam logic [1:0] GPIO_DATA_OUT = 2'd0;
    localparam logic [1:0] GPIO_DIR      = 2'd1;
    localparam logic [1:0] GPIO_DATA_IN  = 2'd2;
    localparam logic [1:0] GPIO_IRQ_STAT = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1
    } bus_state_t;

endpackage

// File: rtl/gpio_sync2.sv
// Parameterised-width two-flop synchronizer for asynchronous pin inputs.
// Both stages clear to 0 on synchronous reset.
module gpio_sync2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             srst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_reg;
    logic [WIDTH-1:0] sync_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            meta_reg <= '0;
            sync_reg <= '0;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/wb_gpio8.sv
// Wishbone B4 classic slave with eight GPIO lines (DATA_OUT, DIR, DATA_IN, IRQ_STAT).
// Define WB_GPIO8_IRQ_EN to enable rising-edge interrupts; otherwise irq_o is tied low.
module wb_gpio8 #(
    parameter logic [7:0] OUT_RESET = 8'h00,
    parameter logic [7:0] DIR_RESET = 8'h00
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    input  logic [7:0]  gpio_i,
    output logic [7:0]  gpio_o,
    output logic [7:0]  gpio_oe_o,
    output logic        irq_o
);
    import wb_gpio8_pkg::*;

    bus_state_t state_reg, state_next;
    logic [7:0] out_reg, dir_reg, dat_reg;
    logic [7:0] sync_q;
    logic [7:0] irq_stat_val;
    logic [7:0] rd_data;
    logic [1:0] adr;
    logic       bus_hit;
    logic       wr_en;
    logic       unused_ok;

    assign unused_ok = &{1'b0, wb_adr_i[31:4], wb_adr_i[1:0], wb_dat_i[31:8], wb_sel_i[3:1]};

    gpio_sync2 #(.WIDTH(8)) u_sync (
        .clk  (wb_clk_i),
        .srst (wb_rst_i),
        .d    (gpio_i),
        .q    (sync_q)
    );

    assign adr     = wb_adr_i[3:2];
    // Only IDLE accepts a strobe, which is what forces acks onto alternate cycles.
    assign bus_hit = (state_reg == ST_IDLE) && wb_cyc_i && wb_stb_i;
    assign wr_en   = bus_hit && wb_we_i && wb_sel_i[0];

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (bus_hit) state_next = ST_ACK;
            ST_ACK:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        rd_data = 8'h00;
        case (adr)
            GPIO_DATA_OUT: rd_data = out_reg;
            GPIO_DIR:      rd_data = dir_reg;
            GPIO_DATA_IN:  rd_data = sync_q;
            GPIO_IRQ_STAT: rd_data = irq_stat_val;
            default:       rd_data = 8'h00;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_reg <= ST_IDLE;
            out_reg   <= OUT_RESET;
            dir_reg   <= DIR_RESET;
            dat_reg   <= 8'h00;
        end else begin
            state_reg <= state_next;
            if (bus_hit) dat_reg <= rd_data;
            if (wr_en && adr == GPIO_DATA_OUT) out_reg <= wb_dat_i[7:0];
            if (wr_en && adr == GPIO_DIR)      dir_reg <= wb_dat_i[7:0];
        end
    end

    assign wb_ack_o  = (state_reg == ST_ACK);
    assign wb_dat_o  = {24'h000000, dat_reg};
    assign gpio_o    = out_reg;
    assign gpio_oe_o = dir_reg;

`ifdef WB_GPIO8_IRQ_EN
    logic [7:0] sync_prev_reg;
    logic [7:0] irq_stat_reg, irq_stat_next;
    logic [7:0] irq_clr;
    logic       irq_reg;

    assign irq_clr = (wr_en && adr == GPIO_IRQ_STAT) ? wb_dat_i[7:0] : 8'h00;

    // A fresh rising edge outranks a same-cycle W1C so no event is lost.
    for (genvar gi = 0; gi < 8; gi++) begin : g_irq_bit
        assign irq_stat_next[gi] = (sync_q[gi] && !sync_prev_reg[gi]) ? 1'b1 :
                                   (irq_clr[gi] ? 1'b0 : irq_stat_reg[gi]);
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            sync_prev_reg <= 8'h00;
            irq_stat_reg  <= 8'h00;
            irq_reg       <= 1'b0;
        end else begin
            sync_prev_reg <= sync_q;
            irq_stat_reg  <= irq_stat_next;
            irq_reg       <= |irq_stat_reg;
        end
    end

    assign irq_stat_val = irq_stat_reg;
    assign irq_o        = irq_reg;
`else
    assign irq_stat_val = 8'h00;
    assign irq_o        = 1'b0;
`endif

endmodule

// File: tb/tb_wb_gpio8.sv
// Directed bench for wb_gpio8: read data goes through an expected-value queue that is
// popped on every read ack; IRQ checks follow the WB_GPIO8_IRQ_EN build option.
module tb_wb_gpio8;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] adr, dat_w, dat_r;
    logic [3:0]  sel;
    logic        we, cyc, stb, ack;
    logic [7:0]  gpio_i, gpio_o, gpio_oe;
    logic        irq;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    wb_gpio8 #(.OUT_RESET(8'h00), .DIR_RESET(8'h00)) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .wb_adr_i  (adr),
        .wb_dat_i  (dat_w),
        .wb_sel_i  (sel),
        .wb_we_i   (we),
        .wb_cyc_i  (cyc),
        .wb_stb_i  (stb),
        .wb_dat_o  (dat_r),
        .wb_ack_o  (ack),
        .gpio_i    (gpio_i),
        .gpio_o    (gpio_o),
        .gpio_oe_o (gpio_oe),
        .irq_o     (irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic pop_read(input string tag);
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $error("FAIL %s: observed read %h expected none queued", tag, dat_r);
        end else begin
            check(tag, dat_r, exp_q.pop_front());
        end
    endtask

    // Called just after a negedge; returns just after a negedge with the bus idle.
    task automatic wb_cycle(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s, input logic w);
        check("ack_before", {31'b0, ack}, 32'd0);
        adr = {28'h0, a}; dat_w = d; sel = s; we = w; cyc = 1'b1; stb = 1'b1;
        @(negedge clk);
        check("ack_latency", {31'b0, ack}, 32'd1);
        if (!w) pop_read($sformatf("read_%h", a));
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(negedge clk);
        check("ack_drop", {31'b0, ack}, 32'd0);
        $display("wb %s adr=%h dat=%h sel=%b", w ? "WR" : "RD", a, w ? d : dat_r, s);
    endtask

    initial begin
        int acks;
        rst = 1'b1; adr = '0; dat_w = '0; sel = '0; we = 0; cyc = 0; stb = 0; gpio_i = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_gpio_o", {24'h0, gpio_o}, 32'h00);
        check("rst_gpio_oe", {24'h0, gpio_oe}, 32'h00);
        check("rst_ack", {31'b0, ack}, 32'd0);
        check("rst_irq", {31'b0, irq}, 32'd0);
        check("rst_dat_o", dat_r, 32'h0);
        rst = 1'b0;

        wb_cycle(4'h4, 32'h000000F0, 4'b0001, 1'b1);
        check("dir_f0", {24'h0, gpio_oe}, 32'hF0);
        wb_cycle(4'h0, 32'h000000A5, 4'b0001, 1'b1);
        check("out_a5", {24'h0, gpio_o}, 32'hA5);
        exp_q.push_back(32'h000000A5);
        wb_cycle(4'h0, 32'h0, 4'b0001, 1'b0);
        wb_cycle(4'h0, 32'h0000003C, 4'b0010, 1'b1);
        check("sel_masked", {24'h0, gpio_o}, 32'hA5);
        exp_q.push_back(32'h000000F0);
        wb_cycle(4'h4, 32'h0, 4'b0001, 1'b0);

        // Pin change and read strobe share a cycle: first read sees the old value.
        gpio_i = 8'h81;
        exp_q.push_back(32'h00000000);
        wb_cycle(4'h8, 32'h0, 4'b0001, 1'b0);
        exp_q.push_back(32'h00000081);
        wb_cycle(4'h8, 32'h0, 4'b0001, 1'b0);
        wb_cycle(4'h8, 32'h000000FF, 4'b0001, 1'b1);
        exp_q.push_back(32'h00000081);
        wb_cycle(4'h8, 32'h0, 4'b0001, 1'b0);

        // Strobe held for six cycles.
        acks = 0;
        adr = 32'h4; we = 1'b0; sel = 4'b0001; cyc = 1'b1; stb = 1'b1;
        for (int i = 0; i < 6; i++) begin
            check($sformatf("hold_ack_%0d", i), {31'b0, ack}, 32'(i % 2));
            if (ack) begin
                acks++;
                exp_q.push_back(32'h000000F0);
                pop_read("hold_read");
            end
            if (i == 5) begin cyc = 1'b0; stb = 1'b0; end
            @(negedge clk);
        end
        check("hold_ack_count", 32'(acks), 32'd3);
        $display("wb hold-strobe acks=%0d", acks);

`ifdef WB_GPIO8_IRQ_EN
        check("irq_from_81", {31'b0, irq}, 32'd1);
        wb_cycle(4'hC, 32'h000000FF, 4'b0001, 1'b1);
        check("irq_cleared_all", {31'b0, irq}, 32'd0);
        gpio_i = 8'h85;
        repeat (4) @(negedge clk);
        check("irq_bit2", {31'b0, irq}, 32'd1);
        exp_q.push_back(32'h00000004);
        wb_cycle(4'hC, 32'h0, 4'b0001, 1'b0);
        wb_cycle(4'hC, 32'h00000004, 4'b0001, 1'b1);
        check("irq_w1c", {31'b0, irq}, 32'd0);
        gpio_i = 8'h81;
        repeat (3) @(negedge clk);
        gpio_i = 8'h85;
        repeat (2) @(negedge clk);
        wb_cycle(4'hC, 32'h00000004, 4'b0001, 1'b1);
        exp_q.push_back(32'h00000004);
        wb_cycle(4'hC, 32'h0, 4'b0001, 1'b0);
        check("irq_set_wins", {31'b0, irq}, 32'd1);
`else
        check("irq_tied_low", {31'b0, irq}, 32'd0);
        wb_cycle(4'hC, 32'h000000FF, 4'b0001, 1'b1);
        exp_q.push_back(32'h00000000);
        wb_cycle(4'hC, 32'h0, 4'b0001, 1'b0);
        check("irq_still_low", {31'b0, irq}, 32'd0);
`endif

        // Reset coinciding with a strobe: transfer is lost and no ack appears.
        adr = 32'h0; dat_w = 32'hFF; sel = 4'b0001; we = 1'b1; cyc = 1'b1; stb = 1'b1; rst = 1'b1;
        @(negedge clk);
        check("midrst_ack", {31'b0, ack}, 32'd0);
        check("midrst_gpio_o", {24'h0, gpio_o}, 32'h00);
        rst = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(negedge clk);
        check("midrst_ack_after", {31'b0, ack}, 32'd0);
        check("midrst_no_write", {24'h0, gpio_o}, 32'h00);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_gpio8.md
# wb_gpio8

Wishbone B4 classic slave providing eight bidirectional GPIO lines, mapped as a peripheral on the picorv32 SoC data bus. Sits directly downstream of the SoC's Wishbone interconnect: consumes bus cycles from the CPU and drives the board LED/IO pins, returning synchronized pin state. Runs on the 24 MHz Wishbone clock domain produced by the clock/reset generator. Pin tristating happens at board top level from `gpio_o`/`gpio_oe_o`.

## Interface
Parameters:
- `OUT_RESET`, 8'h00: reset value of the DATA_OUT register.
- `DIR_RESET`, 8'h00: reset value of DIR; 1 = output.

Ports:
- `wb_clk_i`  in  1  Wishbone clock; the only clock.
- `wb_rst_i`  in  1  reset, synchronous, active-high.
- `wb_adr_i`  in  32  byte address; only [3:2] decoded.
- `wb_dat_i`  in  32  write data.
- `wb_sel_i`  in  4  byte selects; only [0] used.
- `wb_we_i`  in  1  write enable.
- `wb_cyc_i`  in  1  cycle valid.
- `wb_stb_i`  in  1  strobe.
- `wb_dat_o`  out  32  read data; [31:8] always 0.
- `wb_ack_o`  out  1  transfer acknowledge.
- `gpio_i`  in  8  raw asynchronous pin inputs.
- `gpio_o`  out  8  pin output values (DATA_OUT).
- `gpio_oe_o`  out  8  per-pin output enable (DIR).
- `irq_o`  out  1  level interrupt (see Configuration).

## Operation
- Register map, word offsets `wb_adr_i[3:2]`:
  - 0x0 DATA_OUT: RW [7:0].
  - 0x4 DIR: RW [7:0].
  - 0x8 DATA_IN: RO, synchronized `gpio_i`; writes ignored.
  - 0xC IRQ_STAT: W1C [7:0] (with macro); otherwise reads 0, writes ignored.
- Write takes effect only when `wb_sel_i[0]`=1; other selects ignored.
- DATA_IN reflects all 8 pins regardless of DIR.
- `gpio_i` passes through a 2-flop synchronizer before any use.
- Bus FSM, two states: IDLE, ACK.
  - IDLE: `cyc&stb&!ack` → register write (if we), capture read data, go ACK with `wb_ack_o`=1.
  - ACK: `wb_ack_o` drops next cycle, return IDLE.
- A strobe held high produces acks on alternate cycles; no back-to-back acks.
- `wb_dat_o` is valid only in the ack cycle; holds its last value otherwise.
- Deasserting cyc/stb while ack is pending does not cancel it; the write has already happened.
- Reset values: `wb_ack_o`=0, `wb_dat_o`=0, `gpio_o`=OUT_RESET, `gpio_oe_o`=DIR_RESET, synchronizer flops 0, IRQ_STAT 0, `irq_o`=0.
- Reset mid-cycle: state returns to IDLE, ack is dropped, the pending transfer is lost, and the master must retry.

## Timing
- Ack latency is one cycle. Strobe is sampled at edge N; `wb_ack_o` and read data are valid after edge N, during cycle N+1.
- Write side effect: register updates at edge N; `gpio_o`/`gpio_oe_o` change after edge N.
- Pin-to-DATA_IN latency: 2 edges through the synchronizer. A read sampled at edge N returns the synchronizer output as of edge N.
- `irq_o` is registered: it asserts one cycle after the IRQ_STAT bit sets.

## Configuration
- Macro `WB_GPIO8_IRQ_EN`.
- Defined:
  - Rising edge on a synchronized input (previous 0, current 1) sets the matching IRQ_STAT bit.
  - `irq_o` = OR of IRQ_STAT, registered.
  - Writing 1 to a bit clears it. If a new edge and a W1C hit the same bit in the same cycle, the set wins.
  - Edge detection uses one extra flop after the synchronizer.
- Undefined:
  - No edge flop and no IRQ_STAT storage.
  - `irq_o` is tied 0; offset 0xC reads 0.

## Structure
- Shared package `wb_gpio8_pkg`: register offset constants (`GPIO_DATA_OUT`, `GPIO_DIR`, `GPIO_DATA_IN`, `GPIO_IRQ_STAT`) and the 2-bit bus-state enum.
- One sub-module, `gpio_sync2`: parameterised-width two-flop synchronizer with synchronous reset to 0; instantiated with width 8.

## Test plan
- Reset: hold `wb_rst_i` 2 cycles → `gpio_o`=00, `gpio_oe_o`=00, `wb_ack_o`=0, `irq_o`=0.
- Write DIR=0xF0, then DATA_OUT=0xA5 with sel=4'b0001 → each ack one cycle after stb; `gpio_oe_o`=F0, `gpio_o`=A5. Readback of 0x0 returns 0x000000A5.
- Write DATA_OUT=0x3C with sel=4'b0010 → ack asserted, `gpio_o` stays A5.
- Drive `gpio_i`=0x81 → read 0x8 returns 0x81 only when issued ≥2 cycles after the pin change; a read sampled at edge 1 returns the old value.
- Hold stb high for 6 cycles → ack pattern 0,1,0,1,0,1; exactly 3 transfers.
- (`WB_GPIO8_IRQ_EN`) `gpio_i[2]` 0→1 → IRQ_STAT=0x04 and `irq_o`=1. Write 0x04 to 0xC → `irq_o`=0. A W1C coinciding with a new edge on bit 2 → bit stays set.
